ub_ring_buffer: RTL and testbench
=================================

Name: ub_ring_buffer

Overview:
- Parametrised unified buffer with N-lane compacting writes, M-lane registered reads, circular addressing and occupancy tracking.
- Sits between systolic-array/activation outputs (write side) and the weight/input feeders (read side).
- Entries are consumed in FIFO order. Full/empty, count and sticky error flags are exported to the control unit.

Parameters:
DATA_WIDTH, 16, bits per entry (fixed-point word)
DEPTH, 64, number of entries; any value >= 2 (not restricted to a power of two)
NUM_WR_CH, 2, write lanes per cycle (1..DEPTH)
NUM_RD_CH, 2, read lanes per cycle (1..DEPTH)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-low (asserted when 0)
clear_in  input  1  synchronous flush: pointers, count and error flags go to 0; memory is not cleared
wr_data_in  input  NUM_WR_CH*DATA_WIDTH  lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
wr_valid_in  input  NUM_WR_CH  per-lane write valid
rd_req_in  input  1  read request
rd_count_in  input  $clog2(NUM_RD_CH+1)  entries to read this request (1..NUM_RD_CH)
rd_data_out  output  NUM_RD_CH*DATA_WIDTH  read data, lane layout as for writes
rd_valid_out  output  NUM_RD_CH  per-lane read-data valid
count_out  output  $clog2(DEPTH+1)  current occupancy
full_out  output  1  count_out == DEPTH
empty_out  output  1  count_out == 0
overflow_out  output  1  sticky: a write was rejected
underflow_out  output  1  sticky: a read was rejected

Behaviour:
- Reset (rst=0, asynchronous):
  - wr_ptr, rd_ptr and count go to 0.
  - rd_data_out, rd_valid_out, overflow_out and underflow_out go to 0.
  - empty_out=1, full_out=0.
  - Memory contents are zeroed.
- Reset mid-operation: any pending read result is discarded; rd_valid_out=0 on the first edge after release.
- clear_in has priority over reads and writes in the same cycle. Both are ignored that cycle, and rd_valid_out=0 on the next cycle.
- Write, nw = popcount(wr_valid_in):
  - Valid lanes are compacted in ascending lane order. The j-th valid lane is written to mem[(wr_ptr+j) mod DEPTH].
  - wr_ptr advances by nw modulo DEPTH.
  - Invalid lanes in between leave no holes. Example: wr_valid_in=2'b10 writes lane 1 to mem[wr_ptr].
- Write acceptance is all-or-nothing. If nw > DEPTH - count (using the count before this edge), nothing is written, wr_ptr holds and overflow_out is set.
- Read:
  - A read is accepted when rd_req_in=1 and 1 <= rd_count_in <= NUM_RD_CH and rd_count_in <= count (before this edge).
  - Accepted read: on the next edge, lane k gets mem[(rd_ptr+k) mod DEPTH] with rd_valid_out[k]=1 for k < rd_count_in. Remaining lanes output 0 with valid 0.
  - rd_ptr advances by rd_count_in modulo DEPTH.
  - Read latency is one cycle.
- A rejected read (count too large, zero, or > NUM_RD_CH) sets underflow_out, produces rd_valid_out=0 and leaves rd_ptr unchanged.
- With no accepted read, rd_valid_out=0 and rd_data_out=0 the next cycle.
- Simultaneous read and write:
  - Both are checked against the pre-edge count. There is no same-cycle write-to-read bypass.
  - count_next = count + nw_accepted - nr_accepted.
  - A write to a full buffer is rejected even if a read frees space in the same cycle.
- Pointer arithmetic uses $clog2(DEPTH)+1 bit intermediates before the modulo, so non-power-of-two DEPTH wraps correctly.
- full_out, empty_out and count_out are registered and consistent with each other every cycle.
- overflow_out and underflow_out clear only on reset or clear_in.

Test Plan (DATA_WIDTH=16, DEPTH=8, NUM_WR_CH=2, NUM_RD_CH=2):
1. Release reset, then write lanes {0x0001,0x0002} valid=2'b11 for 4 cycles -> count_out=8, full_out=1, overflow_out=0. A fifth write (valid=2'b11) -> overflow_out=1, count_out stays 8.
2. From empty, write wr_valid_in=2'b10 with lane1=0xBEEF, then read rd_count_in=1 -> next cycle rd_data_out lane0=0xBEEF, rd_valid_out=2'b01, empty_out=1.
3. Wrap-around: write 6 entries, read 6, then write 0x00A0..0x00A5 (3 cycles), read 2 per cycle for 3 cycles -> lanes return 0x00A0,0x00A1 / 0x00A2,0x00A3 / 0x00A4,0x00A5 in order, wr_ptr and rd_ptr wrapped past index 7.
4. With count=1, request rd_count_in=2 -> underflow_out=1, rd_valid_out=0, count_out=1. A following rd_count_in=1 succeeds.
5. With count=7, write 2 entries and read 2 in the same cycle -> write rejected (overflow_out=1), read accepted, count_out=5.
6. Assert rst=0 asynchronously mid-stream (count=5, read in flight) -> all outputs 0 immediately, empty_out=1. After release, one read request -> underflow_out=1.

Source files
------------

// File: rtl/ub_ring_buffer_if.sv
// Bus bundle for ub_ring_buffer: write lanes, read request, read data and status.
interface ub_ring_buffer_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned NUM_WR_CH  = 2,
  parameter int unsigned NUM_RD_CH  = 2
);
  localparam int unsigned RCW = $clog2(NUM_RD_CH + 1);
  localparam int unsigned CW  = $clog2(DEPTH + 1);

  logic                            clear_in;
  logic [NUM_WR_CH*DATA_WIDTH-1:0] wr_data_in;
  logic [NUM_WR_CH-1:0]            wr_valid_in;
  logic                            rd_req_in;
  logic [RCW-1:0]                  rd_count_in;
  logic [NUM_RD_CH*DATA_WIDTH-1:0] rd_data_out;
  logic [NUM_RD_CH-1:0]            rd_valid_out;
  logic [CW-1:0]                   count_out;
  logic                            full_out;
  logic                            empty_out;
  logic                            overflow_out;
  logic                            underflow_out;

  // Producer/consumer side (control unit, feeders, testbench)
  modport master (
    output clear_in, wr_data_in, wr_valid_in, rd_req_in, rd_count_in,
    input  rd_data_out, rd_valid_out, count_out, full_out, empty_out,
    input  overflow_out, underflow_out
  );

  // Buffer side
  modport slave (
    input  clear_in, wr_data_in, wr_valid_in, rd_req_in, rd_count_in,
    output rd_data_out, rd_valid_out, count_out, full_out, empty_out,
    output overflow_out, underflow_out
  );
endinterface

// File: rtl/ub_ring_buffer.sv
// Unified ring buffer: N-lane compacting writes, M-lane registered FIFO reads,
// circular addressing for any DEPTH >= 2, occupancy and sticky error flags.
module ub_ring_buffer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned NUM_WR_CH  = 2,
  parameter int unsigned NUM_RD_CH  = 2
) (
  input  logic          clk,
  input  logic          rst,
  ub_ring_buffer_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  // Fold a sum of two in-range quantities (< 2*DEPTH) back into [0, DEPTH)
  function automatic logic [AW-1:0] wrap(input logic [PW-1:0] s);
    logic [PW-1:0] r;
    r = (s >= PW'(DEPTH)) ? (s - PW'(DEPTH)) : s;
    return AW'(r);
  endfunction

  logic [DATA_WIDTH-1:0]           mem_q [DEPTH];
  logic [AW-1:0]                   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]                   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                   count_q, count_d;
  logic                            full_q, empty_q;
  logic                            ovf_q, ovf_d;
  logic                            udf_q, udf_d;
  logic [NUM_RD_CH*DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [NUM_RD_CH-1:0]            rd_valid_q, rd_valid_d;

  logic [AW-1:0] wr_addr [NUM_WR_CH];
  logic [PW-1:0] nw, nr, free;
  logic          wr_en, rd_ok;

  // Lane compaction, acceptance decisions and next-state computation
  always_comb begin
    nw = '0;
    for (int k = 0; k < int'(NUM_WR_CH); k++) begin
      wr_addr[k] = wrap(PW'(wr_ptr_q) + nw);
      if (bus.wr_valid_in[k]) nw = nw + PW'(1);
    end

    free  = PW'(DEPTH) - PW'(count_q);
    nr    = PW'(bus.rd_count_in);
    wr_en = !bus.clear_in && (nw != '0) && (nw <= free);
    rd_ok = !bus.clear_in && bus.rd_req_in && (nr != '0) &&
            (nr <= PW'(NUM_RD_CH)) && (nr <= PW'(count_q));

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    rd_data_d  = '0;
    rd_valid_d = '0;

    for (int k = 0; k < int'(NUM_RD_CH); k++) begin
      if (rd_ok && (PW'(k) < nr)) begin
        rd_valid_d[k]                           = 1'b1;
        rd_data_d[k*DATA_WIDTH +: DATA_WIDTH]   = mem_q[wrap(PW'(rd_ptr_q) + PW'(k))];
      end
    end

    if (bus.clear_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_en) wr_ptr_d = wrap(PW'(wr_ptr_q) + nw);
      if (nw > free) ovf_d = 1'b1;
      if (rd_ok) rd_ptr_d = wrap(PW'(rd_ptr_q) + nr);
      if (bus.rd_req_in && !rd_ok) udf_d = 1'b1;
      count_d = CW'(PW'(count_q) + (wr_en ? nw : '0) - (rd_ok ? nr : '0));
    end
  end

  // Pointers, occupancy, flags and the registered read port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= (count_d == CW'(DEPTH));
      empty_q    <= (count_d == '0);
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Storage: zeroed on reset, untouched by clear_in
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      for (int k = 0; k < int'(NUM_WR_CH); k++) begin
        if (wr_en && bus.wr_valid_in[k])
          mem_q[wr_addr[k]] <= bus.wr_data_in[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign bus.rd_data_out   = rd_data_q;
  assign bus.rd_valid_out  = rd_valid_q;
  assign bus.count_out     = count_q;
  assign bus.full_out      = full_q;
  assign bus.empty_out     = empty_q;
  assign bus.overflow_out  = ovf_q;
  assign bus.underflow_out = udf_q;
endmodule

// File: tb/tb_ub_ring_buffer.sv
// Testbench for ub_ring_buffer: directed scenarios plus random traffic,
// every cycle compared against a queue-based FIFO reference model.
module tb_ub_ring_buffer;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned NWR   = 2;
  localparam int unsigned NRD   = 2;

  logic clk;
  logic rst_n;

  logic              clr;
  logic [NWR-1:0]    wv;
  logic [NWR*DW-1:0] wd;
  logic              req;
  logic [1:0]        cnt;

  ub_ring_buffer_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_WR_CH(NWR), .NUM_RD_CH(NRD)) bus ();

  assign bus.clear_in    = clr;
  assign bus.wr_valid_in = wv;
  assign bus.wr_data_in  = wd;
  assign bus.rd_req_in   = req;
  assign bus.rd_count_in = cnt;

  ub_ring_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_WR_CH(NWR), .NUM_RD_CH(NRD)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: FIFO contents as a queue plus expected registered outputs
  logic [DW-1:0]     mq [$];
  logic              m_ovf, m_udf;
  logic [NRD*DW-1:0] m_data;
  logic [NRD-1:0]    m_valid;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    m_data  = '0;
    m_valid = '0;
  endtask

  // Apply the FIFO rules to the inputs about to be sampled at the next edge
  task automatic model_step();
    int sz;
    int nwr;
    if (clr) begin
      model_reset();
    end else begin
      sz      = mq.size();
      m_data  = '0;
      m_valid = '0;
      if (req) begin
        if (cnt >= 1 && int'(cnt) <= int'(NRD) && int'(cnt) <= sz) begin
          for (int i = 0; i < int'(cnt); i++) begin
            m_data[i*DW +: DW] = mq.pop_front();
            m_valid[i]         = 1'b1;
          end
        end else begin
          m_udf = 1'b1;
        end
      end
      nwr = 0;
      for (int k = 0; k < int'(NWR); k++) if (wv[k]) nwr++;
      if (nwr > int'(DEPTH) - sz) m_ovf = 1'b1;
      else for (int k = 0; k < int'(NWR); k++) if (wv[k]) mq.push_back(wd[k*DW +: DW]);
    end
  endtask

  task automatic check_all();
    check("count",     64'(bus.count_out),     64'(mq.size()));
    check("full",      64'(bus.full_out),      64'(mq.size() == int'(DEPTH)));
    check("empty",     64'(bus.empty_out),     64'(mq.size() == 0));
    check("overflow",  64'(bus.overflow_out),  64'(m_ovf));
    check("underflow", 64'(bus.underflow_out), 64'(m_udf));
    check("rd_valid",  64'(bus.rd_valid_out),  64'(m_valid));
    check("rd_data",   64'(bus.rd_data_out),   64'(m_data));
  endtask

  // One clock: drive at the falling edge, let the rising edge capture, check at the next falling edge
  task automatic cyc(input logic c, input logic [NWR-1:0] v, input logic [NWR*DW-1:0] d,
                     input logic r, input logic [1:0] n);
    clr = c; wv = v; wd = d; req = r; cnt = n;
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    cyc(1'b0, '0, '0, 1'b0, 2'd0);
  endtask

  initial begin
    clr = 1'b0; wv = '0; wd = '0; req = 1'b0; cnt = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Fill to full with two-lane writes, then one more write overflows
    repeat (4) cyc(1'b0, 2'b11, {16'h0002, 16'h0001}, 1'b0, 2'd0);
    check("fill_count", 64'(bus.count_out), 64'd8);
    check("fill_full",  64'(bus.full_out),  64'd1);
    check("fill_ovf",   64'(bus.overflow_out), 64'd0);
    cyc(1'b0, 2'b11, {16'h0002, 16'h0001}, 1'b0, 2'd0);
    check("over_ovf",   64'(bus.overflow_out), 64'd1);
    check("over_count", 64'(bus.count_out), 64'd8);

    // Clear beats a simultaneous read and write
    cyc(1'b1, 2'b11, {16'h1111, 16'h2222}, 1'b1, 2'd2);
    check("clr_count", 64'(bus.count_out), 64'd0);
    check("clr_valid", 64'(bus.rd_valid_out), 64'd0);

    // Sparse lane mask compacts lane 1 into the head slot
    cyc(1'b0, 2'b10, {16'hBEEF, 16'hDEAD}, 1'b0, 2'd0);
    cyc(1'b0, 2'b00, '0, 1'b1, 2'd1);
    check("sparse_data",  64'(bus.rd_data_out[15:0]), 64'h0000BEEF);
    check("sparse_valid", 64'(bus.rd_valid_out), 64'd1);
    check("sparse_empty", 64'(bus.empty_out), 64'd1);

    // Wrap-around of both pointers
    repeat (3) cyc(1'b0, 2'b11, 32'($urandom), 1'b0, 2'd0);
    repeat (3) cyc(1'b0, 2'b00, '0, 1'b1, 2'd2);
    for (int i = 0; i < 3; i++) cyc(1'b0, 2'b11, {16'(16'h00A1 + 2*i), 16'(16'h00A0 + 2*i)}, 1'b0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 2'b00, '0, 1'b1, 2'd2);
      check("wrap_data", 64'(bus.rd_data_out), 64'({16'(16'h00A1 + 2*i), 16'(16'h00A0 + 2*i)}));
    end

    // Read larger than occupancy is rejected, a fitting one then succeeds
    cyc(1'b0, 2'b01, {16'h0, 16'h0777}, 1'b0, 2'd0);
    cyc(1'b0, 2'b00, '0, 1'b1, 2'd2);
    check("udf_flag",  64'(bus.underflow_out), 64'd1);
    check("udf_valid", 64'(bus.rd_valid_out), 64'd0);
    check("udf_count", 64'(bus.count_out), 64'd1);
    cyc(1'b0, 2'b00, '0, 1'b1, 2'd1);
    check("udf_recover", 64'(bus.rd_data_out), 64'h0777);

    // Write rejected against the pre-edge count while the same-cycle read is accepted
    cyc(1'b1, '0, '0, 1'b0, 2'd0);
    repeat (3) cyc(1'b0, 2'b11, 32'($urandom), 1'b0, 2'd0);
    cyc(1'b0, 2'b01, 32'($urandom), 1'b0, 2'd0);
    cyc(1'b0, 2'b11, 32'($urandom), 1'b1, 2'd2);
    check("rw_ovf",   64'(bus.overflow_out), 64'd1);
    check("rw_count", 64'(bus.count_out), 64'd5);
    check("rw_valid", 64'(bus.rd_valid_out), 64'd3);

    // Asynchronous reset with a read in flight
    clr = 1'b0; wv = '0; wd = '0; req = 1'b1; cnt = 2'd2;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(bus.rd_valid_out), 64'd0);
    check("arst_data",  64'(bus.rd_data_out), 64'd0);
    check("arst_count", 64'(bus.count_out), 64'd0);
    check("arst_empty", 64'(bus.empty_out), 64'd1);
    check("arst_flags", 64'({bus.overflow_out, bus.underflow_out, bus.full_out}), 64'd0);
    model_reset();
    req = 1'b0; cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    cyc(1'b0, 2'b00, '0, 1'b1, 2'd1);
    check("arst_udf", 64'(bus.underflow_out), 64'd1);

    // Random traffic against the model
    for (int t = 0; t < 600; t++) begin
      logic       c;
      logic [1:0] n;
      c = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 9) == 0) n = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3;
      else n = 2'($urandom_range(1, 2));
      cyc(c, 2'($urandom_range(0, 3)), 32'($urandom), 1'($urandom_range(0, 1)), n);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
